// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store unit turning byte/half/word accesses into whole-word memory cycles
module lsu_mem_ctrl #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        mem_write_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);
  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;
  state_t      state, state_next;
  logic        write_q, uns_q, fault_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, merge_q, rdata_q;
  logic        accept, fault, sub_store;
  logic [4:0]  bsh, hsh;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] load_val, merged;
  // request decode, lane extraction/merge, next state and outputs
  always_comb begin
    accept = req_valid && state == IDLE;
    fault = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
            (req_size == 2'b10 && req_addr[1:0] != 2'b00) || req_addr >= 32'(MEM_BYTES);
    sub_store = write_q && size_q != 2'b10;
    bsh = {addr_q[1:0], 3'b000};
    hsh = {addr_q[1], 4'b0000};
    lb = 8'(mem_read_data >> bsh);
    lh = 16'(mem_read_data >> hsh);
    load_val = size_q == 2'b00 ? {{24{lb[7] && !uns_q}}, lb} :
               size_q == 2'b01 ? {{16{lh[15] && !uns_q}}, lh} : mem_read_data;
    merged = size_q == 2'b00 ? (merge_q & ~(32'hFF << bsh)) | ({24'b0, wdata_q[7:0]} << bsh) :
                               (merge_q & ~(32'hFFFF << hsh)) | ({16'b0, wdata_q[15:0]} << hsh);
    state_next = state == IDLE   ? (accept ? (fault ? RESP : ACCESS) : IDLE) :
                 state == ACCESS ? (sub_store ? WRITE : RESP) :
                 state == WRITE  ? RESP : IDLE;
    req_ready = state == IDLE;
    resp_valid = state == RESP;
    resp_fault = resp_valid && fault_q;
    resp_rdata = resp_valid ? rdata_q : 32'b0;
    mem_addr = (state == ACCESS || state == WRITE) ? {addr_q[31:2], 2'b00} : 32'b0;
    mem_write_en = !rst && ((state == ACCESS && write_q && !sub_store) || state == WRITE);
    mem_write_data = mem_write_en ? (state == WRITE ? merged : wdata_q) : 32'b0;
  end
  // state register, request capture on accept, load result and merge word capture in ACCESS
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_next;
    if (accept) begin
      write_q <= req_write;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      fault_q <= fault;
      rdata_q <= 32'b0;
    end
    if (state == ACCESS) begin
      merge_q <= mem_read_data;
      if (!write_q) rdata_q <= load_val;
    end
  end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed self-checking bench for lsu_mem_ctrl with a word memory model
module tb_lsu_mem_ctrl;
  logic        clk = 0, rst = 1;
  logic        req_valid = 0, req_write = 0, req_unsigned = 0;
  logic [1:0]  req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        req_ready, resp_valid, resp_fault, mem_write_en;
  logic [31:0] resp_rdata, mem_addr, mem_write_data, mem_read_data;
  logic [31:0] mem [256];
  int          wr_cnt = 0;
  int          checks = 0, fails = 0;

  lsu_mem_ctrl #(.MEM_BYTES(1024)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault), .mem_write_en(mem_write_en),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;
  assign mem_read_data = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_write_en) begin
    mem[mem_addr[9:2]] <= mem_write_data;
    wr_cnt <= wr_cnt + 1;
  end

  // drive one request, wait (bounded) for its response, report latency and the cycle after
  task automatic issue(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                       input logic [31:0] d, output int lat, output logic [31:0] rd,
                       output logic f, output logic extra);
    @(negedge clk);
    req_valid = 1; req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 0; req_write = ~w; req_size = ~sz; req_unsigned = ~u; req_addr = ~a; req_wdata = ~d;
    lat = 99; rd = 0; f = 0; extra = 0;
    for (int k = 1; k <= 8 && lat == 99; k++) begin
      if (resp_valid) begin lat = k; rd = resp_rdata; f = resp_fault; end
      else begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    extra = resp_valid;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    checks++; if (resp_fault !== 1'b0) begin fails++; $display("FAIL reset_resp_fault got %b want 0", resp_fault); end
    checks++; if (resp_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h want 0", resp_rdata); end
    checks++; if (mem_write_en !== 1'b0) begin fails++; $display("FAIL reset_write_en got %b want 0", mem_write_en); end
    checks++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
  endtask

  task automatic test_word;
    int lat, base; logic [31:0] rd; logic f, ex;
    base = wr_cnt;
    issue(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, lat, rd, f, ex);
    checks++; if (lat !== 2) begin fails++; $display("FAIL sw_latency got %0d want 2", lat); end
    checks++; if (wr_cnt - base !== 1) begin fails++; $display("FAIL sw_writes got %0d want 1", wr_cnt - base); end
    checks++; if (rd !== 32'h0 || f !== 1'b0) begin fails++; $display("FAIL sw_resp got %h/%b want 0/0", rd, f); end
    checks++; if (ex !== 1'b0) begin fails++; $display("FAIL sw_pulse got %b want 0", ex); end
    base = wr_cnt;
    issue(0, 2'b10, 0, 32'h10, 32'h0, lat, rd, f, ex);
    checks++; if (lat !== 2) begin fails++; $display("FAIL lw_latency got %0d want 2", lat); end
    checks++; if (rd !== 32'hDEADBEEF || f !== 1'b0) begin fails++; $display("FAIL lw_data got %h/%b want deadbeef/0", rd, f); end
    checks++; if (wr_cnt !== base) begin fails++; $display("FAIL lw_no_write got %0d want %0d", wr_cnt, base); end
  endtask

  task automatic test_byte;
    int lat, base; logic [31:0] rd; logic f, ex;
    base = wr_cnt;
    issue(1, 2'b00, 0, 32'h11, 32'hFFFFFF80, lat, rd, f, ex);
    checks++; if (lat !== 3) begin fails++; $display("FAIL sb_latency got %0d want 3", lat); end
    checks++; if (wr_cnt - base !== 1) begin fails++; $display("FAIL sb_writes got %0d want 1", wr_cnt - base); end
    checks++; if (ex !== 1'b0) begin fails++; $display("FAIL sb_pulse got %b want 0", ex); end
    issue(0, 2'b10, 0, 32'h10, 32'h0, lat, rd, f, ex);
    checks++; if (rd !== 32'hDEAD80EF) begin fails++; $display("FAIL sb_word got %h want dead80ef", rd); end
    issue(0, 2'b00, 0, 32'h11, 32'h0, lat, rd, f, ex);
    checks++; if (rd !== 32'hFFFFFF80 || lat !== 2) begin fails++; $display("FAIL lb got %h lat %0d want ffffff80 lat 2", rd, lat); end
    issue(0, 2'b00, 1, 32'h11, 32'h0, lat, rd, f, ex);
    checks++; if (rd !== 32'h00000080) begin fails++; $display("FAIL lbu got %h want 00000080", rd); end
  endtask

  task automatic test_half;
    int lat; logic [31:0] rd; logic f, ex;
    issue(1, 2'b01, 0, 32'h12, 32'hABCD1234, lat, rd, f, ex);
    checks++; if (lat !== 3) begin fails++; $display("FAIL sh_latency got %0d want 3", lat); end
    checks++; if (mem[4] !== 32'h123480EF) begin fails++; $display("FAIL sh_word got %h want 123480ef", mem[4]); end
    issue(0, 2'b01, 0, 32'h12, 32'h0, lat, rd, f, ex);
    checks++; if (rd !== 32'h00001234) begin fails++; $display("FAIL lh got %h want 00001234", rd); end
    issue(0, 2'b01, 1, 32'h10, 32'h0, lat, rd, f, ex);
    checks++; if (rd !== 32'h000080EF) begin fails++; $display("FAIL lhu got %h want 000080ef", rd); end
    issue(0, 2'b01, 0, 32'h10, 32'h0, lat, rd, f, ex);
    checks++; if (rd !== 32'hFFFF80EF) begin fails++; $display("FAIL lh_neg got %h want ffff80ef", rd); end
  endtask

  task automatic test_faults;
    logic        w  [4] = '{0, 1, 0, 1};
    logic [1:0]  sz [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
    logic [31:0] a  [4] = '{32'h13, 32'h11, 32'h10, 32'h400};
    int lat, base; logic [31:0] rd; logic f, ex;
    for (int i = 0; i < 4; i++) begin
      base = wr_cnt;
      issue(w[i], sz[i], 0, a[i], 32'h55AA55AA, lat, rd, f, ex);
      checks++; if (f !== 1'b1 || lat !== 1) begin fails++; $display("FAIL fault%0d got fault %b lat %0d want 1 lat 1", i, f, lat); end
      checks++; if (rd !== 32'h0 || wr_cnt !== base) begin fails++; $display("FAIL fault%0d_side got rdata %h writes %0d want 0 and %0d", i, rd, wr_cnt, base); end
    end
    checks++; if (mem[4] !== 32'h123480EF) begin fails++; $display("FAIL fault_mem got %h want 123480ef", mem[4]); end
  endtask

  task automatic test_back_to_back;
    logic [1:0]  sz  [3] = '{2'b10, 2'b00, 2'b01};
    logic        u   [3] = '{0, 1, 0};
    logic [31:0] a   [3] = '{32'h10, 32'h13, 32'h10};
    logic [31:0] exp [3] = '{32'h123480EF, 32'h00000012, 32'hFFFF80EF};
    int acc_at [3]; logic [31:0] got [3];
    int n_acc = 0, n_resp = 0, busy_low = 0;
    logic acc;
    @(negedge clk);
    req_valid = 1; req_write = 0; req_size = sz[0]; req_unsigned = u[0]; req_addr = a[0];
    for (int c = 0; c < 30 && n_resp < 3; c++) begin
      acc = req_ready && req_valid;
      if (!req_ready && n_acc < 3) busy_low++;
      @(posedge clk); #1;
      if (acc) begin
        acc_at[n_acc] = c; n_acc++;
        if (n_acc < 3) begin req_size = sz[n_acc]; req_unsigned = u[n_acc]; req_addr = a[n_acc]; end
        else req_valid = 0;
      end
      if (resp_valid && n_resp < 3) begin got[n_resp] = resp_rdata; n_resp++; end
      @(negedge clk);
    end
    req_valid = 0;
    checks++; if (n_acc !== 3 || n_resp !== 3) begin fails++; $display("FAIL b2b_counts got %0d/%0d want 3/3", n_acc, n_resp); end
    else begin
      for (int i = 0; i < 2; i++) begin
        checks++; if (acc_at[i+1] - acc_at[i] !== 3) begin fails++; $display("FAIL b2b_gap%0d got %0d want 3", i, acc_at[i+1] - acc_at[i]); end
      end
      for (int i = 0; i < 3; i++) begin
        checks++; if (got[i] !== exp[i]) begin fails++; $display("FAIL b2b_data%0d got %h want %h", i, got[i], exp[i]); end
      end
    end
    checks++; if (busy_low !== 4) begin fails++; $display("FAIL b2b_ready_low got %0d want 4", busy_low); end
  endtask

  task automatic test_reset_in_write;
    int lat, base; logic [31:0] rd; logic f, ex, seen;
    @(negedge clk);
    req_valid = 1; req_write = 1; req_size = 2'b00; req_unsigned = 0; req_addr = 32'h10; req_wdata = 32'h77;
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk); #1;
    checks++; if (mem_write_en !== 1'b1 || mem_addr !== 32'h10) begin fails++; $display("FAIL rstw_pre got en %b addr %h want 1 00000010", mem_write_en, mem_addr); end
    base = wr_cnt;
    rst = 1; #1;
    checks++; if (mem_write_en !== 1'b0) begin fails++; $display("FAIL rstw_suppress got %b want 0", mem_write_en); end
    @(posedge clk); #1;
    rst = 0;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      if (resp_valid) seen = 1;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 1'b0 || wr_cnt !== base) begin fails++; $display("FAIL rstw_drop got resp %b writes %0d want 0 and %0d", seen, wr_cnt, base); end
    issue(0, 2'b10, 0, 32'h10, 32'h0, lat, rd, f, ex);
    checks++; if (rd !== 32'h123480EF) begin fails++; $display("FAIL rstw_word got %h want 123480ef", rd); end
  endtask

  initial begin
    test_reset;
    test_word;
    test_byte;
    test_half;
    test_faults;
    test_back_to_back;
    test_reset_in_write;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
